// File: rtl/window_3x3_gen_if.sv
// Pixel stream in, 3x3 neighbourhood out.
// Slave side is the window generator; master side is whoever drives it.
interface window_3x3_gen_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic [7:0] px0, px1, px2;
  logic [7:0] px3, px4, px5;
  logic [7:0] px6, px7, px8;
  logic       win_valid;
  logic       win_eof;
  logic       err_sof;

  modport master (
    output in_valid, in_data, in_sof,
    input  px0, px1, px2, px3, px4,
    input  px5, px6, px7, px8,
    input  win_valid, win_eof, err_sof
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output px0, px1, px2, px3, px4,
    output px5, px6, px7, px8,
    output win_valid, win_eof, err_sof
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster pixels to 3x3 windows for interior positions.
// Two line buffers plus a shifting 3x3 register window.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic             clk,
  input logic             rst,
  window_3x3_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   col, col_nx, cur_col;
  logic [RW-1:0]   row, row_nx, cur_row;
  logic            accept, emit, last_px;
  logic            last_col, last_row;

  logic [7:0] lb_a [IMG_WIDTH];
  logic [7:0] lb_b [IMG_WIDTH];
  logic [7:0] rd_a, rd_b;
  logic [7:0] win    [9];
  logic [7:0] win_nx [9];
  logic [7:0] pxr    [9];

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    emit     = 1'b0;
    last_px  = 1'b0;
    cur_col  = col;
    cur_row  = row;
    col_nx   = col;
    row_nx   = row;
    unique case (state)
      IDLE:    accept = bus.in_valid && bus.in_sof;
      ACTIVE:  accept = bus.in_valid;
      default: accept = 1'b0;
    endcase
    // sof always restarts the raster, even mid-frame
    if (bus.in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_row = (cur_row == RW'(IMG_HEIGHT - 1));
    if (accept) begin
      state_nx = ACTIVE;
      emit     = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_px  = last_col && last_row;
      if (last_col) begin
        col_nx = '0;
        if (last_row) begin
          row_nx   = '0;
          state_nx = IDLE;
        end else begin
          row_nx = cur_row + RW'(1);
        end
      end else begin
        col_nx = cur_col + CW'(1);
        row_nx = cur_row;
      end
    end
  end

  assign rd_a = lb_a[cur_col];
  assign rd_b = lb_b[cur_col];

  always_comb begin
    win_nx[0] = win[1];
    win_nx[1] = win[2];
    win_nx[2] = rd_a;
    win_nx[3] = win[4];
    win_nx[4] = win[5];
    win_nx[5] = rd_b;
    win_nx[6] = win[7];
    win_nx[7] = win[8];
    win_nx[8] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[cur_col] <= rd_b;
      lb_b[cur_col] <= bus.in_data;
      win           <= win_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      bus.win_valid <= 1'b0;
      bus.win_eof   <= 1'b0;
      bus.err_sof   <= 1'b0;
      for (int i = 0; i < 9; i++) pxr[i] <= '0;
    end else begin
      state         <= state_nx;
      col           <= col_nx;
      row           <= row_nx;
      bus.win_valid <= emit;
      bus.win_eof   <= emit && last_px;
      bus.err_sof   <= accept && bus.in_sof
                       && (state == ACTIVE);
      if (emit) pxr <= win_nx;
    end
  end

  assign bus.px0 = pxr[0];
  assign bus.px1 = pxr[1];
  assign bus.px2 = pxr[2];
  assign bus.px3 = pxr[3];
  assign bus.px4 = pxr[4];
  assign bus.px5 = pxr[5];
  assign bus.px6 = pxr[6];
  assign bus.px7 = pxr[7];
  assign bus.px8 = pxr[8];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: directed frames, random gaps and data,
// checked against a frame-array reference model.
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_3x3_gen_if bus();

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int nwin, neof, nerr;

  logic [7:0]  img [H][W];
  bit          m_act;
  int          m_r, m_c;
  logic [71:0] e_px;
  logic        e_wv, e_eof, e_err;

  function automatic logic [71:0] obs_px();
    return {bus.px0, bus.px1, bus.px2,
            bus.px3, bus.px4, bus.px5,
            bus.px6, bus.px7, bus.px8};
  endfunction

  task automatic chk(input string tag, input logic [71:0] o,
                     input logic [71:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference: remember every accepted pixel by (row,col) position
  task automatic model(input bit v, input logic [7:0] d,
                       input bit s, input bit r);
    e_wv  = 1'b0;
    e_eof = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_act = 0; m_r = 0; m_c = 0; e_px = '0;
      return;
    end
    if (!v) return;
    if (!m_act && !s) return;
    if (s) begin
      e_err = m_act;
      m_r = 0; m_c = 0;
    end
    m_act = 1;
    img[m_r][m_c] = d;
    if (m_r >= 2 && m_c >= 2) begin
      e_wv  = 1'b1;
      e_eof = (m_r == H - 1) && (m_c == W - 1);
      e_px  = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e_px = {e_px[63:0], img[m_r - 2 + i][m_c - 2 + j]};
    end
    if (m_c == W - 1) begin
      m_c = 0;
      if (m_r == H - 1) begin m_r = 0; m_act = 0; end
      else m_r++;
    end else begin
      m_c++;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input bit s, input bit r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sof   = s;
    rst          = r;
    @(posedge clk);
    model(v, d, s, r);
    #1;
    chk("win_valid", 72'(bus.win_valid), 72'(e_wv));
    chk("win_eof",   72'(bus.win_eof),   72'(e_eof));
    chk("err_sof",   72'(bus.err_sof),   72'(e_err));
    chk("px",        obs_px(),           e_px);
    if (bus.win_valid) nwin++;
    if (bus.win_eof)   neof++;
    if (bus.err_sof)   nerr++;
  endtask

  task automatic gap(input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int k = 0; k < g; k++)
      step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
  endtask

  // Feed npix pixels of a frame in raster order, sof on the first
  task automatic frame(input int npix, input bit rnd,
                       input int maxgap);
    int r, c;
    logic [7:0] d;
    for (int n = 0; n < npix; n++) begin
      r = n / W;
      c = n % W;
      d = rnd ? 8'($urandom) : 8'(10 * r + c);
      gap(maxgap);
      step(1'b1, d, n == 0, 1'b0);
      if (!rnd && r == 2 && c == 2)
        chk("first_win", obs_px(), 72'h00_01_02_0a_0b_0c_14_15_16);
      if (!rnd && r == H - 1 && c == W - 1) begin
        chk("last_px8", 72'(bus.px8), 72'd34);
        chk("last_px4", 72'(bus.px4), 72'd23);
      end
    end
  endtask

  task automatic clr();
    nwin = 0; neof = 0; nerr = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;
    rst          = 1'b1;
    m_act = 0; m_r = 0; m_c = 0; e_px = '0;
    clr();

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_px", obs_px(), 72'h0);
    chk("reset_wv", 72'(bus.win_valid), 72'h0);

    clr();
    frame(W * H, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("cont_nwin", 72'(nwin), 72'd6);
    chk("cont_neof", 72'(neof), 72'd1);

    clr();
    frame(W * H, 1'b0, 3);
    gap(3);
    chk("gap_nwin", 72'(nwin), 72'd6);
    chk("gap_neof", 72'(neof), 72'd1);

    clr();
    frame(W * H, 1'b1, 2);
    frame(W * H, 1'b1, 0);
    chk("rnd_nwin", 72'(nwin), 72'd12);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    clr();
    for (int k = 0; k < 7; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("nosof_nwin", 72'(nwin), 72'd0);
    frame(W * H, 1'b0, 1);
    chk("nosof_nwin2", 72'(nwin), 72'd6);
    chk("nosof_nerr", 72'(nerr), 72'd0);

    clr();
    frame(2 * W + 1, 1'b1, 1);
    frame(W * H, 1'b0, 0);
    chk("midsof_nerr", 72'(nerr), 72'd1);
    chk("midsof_nwin", 72'(nwin), 72'd6);

    frame(3 * W + 1, 1'b0, 0);
    step(1'b1, 8'd31, 1'b0, 1'b1);
    chk("rst_px", obs_px(), 72'h0);
    clr();
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    frame(W * H, 1'b0, 0);
    chk("rst_nwin", 72'(nwin), 72'd6);

    clr();
    frame(W * H, 1'b0, 0);
    frame(W * H, 1'b0, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("b2b_nwin", 72'(nwin), 72'd12);
    chk("b2b_neof", 72'(neof), 72'd2);
    chk("b2b_nerr", 72'(nerr), 72'd0);

    clr();
    frame(W * H - 1, 1'b1, 0);
    frame(W * H, 1'b1, 1);
    chk("eofsof_nerr", 72'(nerr), 72'd1);
    chk("eofsof_neof", 72'(neof), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
